// File: rtl/key_matrix_uart_if.sv
// Pin bundle of the key matrix scanner: column strobes out, row sense in,
// UART TX line and the two status LEDs.
// master = the scanner/transmitter, slave = the keyboard/board side.
interface key_matrix_uart_if #(
  parameter int COLS = 5,
  parameter int ROWS = 15
);
  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row_n;
  logic            tx;
  logic            led_act;
  logic            led_ovf;

  modport master (
    output col_n,
    input  row_n,
    output tx,
    output led_act,
    output led_ovf
  );

  modport slave (
    input  col_n,
    output row_n,
    input  tx,
    input  led_act,
    input  led_ovf
  );
endinterface

// File: rtl/key_matrix_uart.sv
// key_matrix_uart: scans a COLS x ROWS key matrix, debounces every key,
// queues make/break event bytes in a FIFO and sends them as UART frames.
// Event byte: bit7 = 0 make / 1 break, bits6:0 = key index (col*ROWS+row).
// Optional feature macro: UART_PARITY_EN adds an even parity bit (8E1 frame);
// without it the frame is 8N1.
// Event FIFO handshake: the key processor offers a push (valid) only on an
// accepted change and it is taken only while the FIFO is not full (ready);
// the TX engine pops only from IDLE while the FIFO is non-empty, and a pop
// in the same cycle never makes room for a push against a full FIFO.
module key_matrix_uart #(
  parameter int COLS       = 5,
  parameter int ROWS       = 15,
  parameter int SCAN_DIV   = 32,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 1042
) (
  input  logic              clk,
  input  logic              rst_n,
  key_matrix_uart_if.master pins,
  output logic [2:0]        o_dbg_tx_state
);
  localparam int NKEYS = COLS * ROWS;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW    = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int DW    = $clog2(SCAN_DIV);
  localparam int BW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int FAW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } tx_state_t;

  // ---------------- scan timing ----------------
  logic          r_active;
  logic [CW-1:0] r_col;
  logic [DW-1:0] r_dwell;
  logic          w_dwell_end;
  logic          w_col_end;

  assign w_dwell_end = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_col_end   = (r_col == CW'(COLS - 1));

  // Column/dwell counters; r_active holds strobes off for the first cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_col    <= '0;
      r_dwell  <= '0;
    end else if (!r_active) begin
      r_active <= 1'b1;
    end else if (w_dwell_end) begin
      r_dwell <= '0;
      r_col   <= w_col_end ? '0 : r_col + CW'(1);
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  assign pins.col_n = r_active ? ~(COLS'(1) << r_col) : '1;

  // ---------------- row sampling ----------------
  logic [ROWS-1:0] r_row_s1;
  logic [ROWS-1:0] r_row_s2;
  logic [ROWS-1:0] r_samp;

  // Two-flop synchroniser on the row inputs, then latch pressed = ~row at d==3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_s1 <= '1;
      r_row_s2 <= '1;
      r_samp   <= '0;
    end else begin
      r_row_s1 <= pins.row_n;
      r_row_s2 <= r_row_s1;
      if (r_active && (r_dwell == DW'(3))) r_samp <= ~r_row_s2;
    end
  end

  // ---------------- key processing ----------------
  logic [NKEYS-1:0] r_stable;
  logic [3:0]       r_cnt [NKEYS];
  logic             r_ovf;
  logic             w_key_slot;
  logic [RW-1:0]    w_row;
  logic [KW-1:0]    w_key;
  logic             w_samp_bit;
  logic [3:0]       w_cnt_cur;
  logic             w_differ;
  logic             w_ripe;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_event;

  assign w_key_slot = r_active && (int'(r_dwell) >= 4) && (int'(r_dwell) < 4 + ROWS);
  assign w_row      = RW'(r_dwell - DW'(4));
  assign w_key      = KW'(int'(r_col) * ROWS + int'(w_row));
  assign w_samp_bit = r_samp[w_row];
  assign w_cnt_cur  = r_cnt[w_key];
  assign w_differ   = w_key_slot && (w_samp_bit != r_stable[w_key]);
  assign w_ripe     = (w_cnt_cur >= 4'(DEBOUNCE - 1));
  assign w_push     = w_differ && w_ripe && !w_full;
  assign w_event    = {~w_samp_bit, 7'(w_key)};

  // One key per cycle: count differing scans, accept on the DEBOUNCE-th, retry if FIFO full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int i = 0; i < NKEYS; i++) r_cnt[i] <= '0;
      r_ovf <= 1'b0;
    end else if (w_key_slot) begin
      if (!w_differ) begin
        r_cnt[w_key] <= '0;
      end else if (!w_ripe) begin
        r_cnt[w_key] <= w_cnt_cur + 4'd1;
      end else if (!w_full) begin
        r_stable[w_key] <= w_samp_bit;
        r_cnt[w_key]    <= '0;
      end else begin
        r_ovf <= 1'b1;
      end
    end
  end

  // ---------------- event FIFO ----------------
  logic [7:0]     r_fifo [FIFO_DEPTH];
  logic [FAW-1:0] r_wptr;
  logic [FAW-1:0] r_rptr;
  logic [FAW:0]   r_count;

  assign w_full  = (r_count == (FAW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // FIFO storage; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_event;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + FAW'(1);
      if (w_pop)  r_rptr <= r_rptr + FAW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FAW+1)'(1);
        2'b01:   r_count <= r_count - (FAW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- UART TX engine ----------------
  tx_state_t     r_state;
  tx_state_t     w_state_next;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_next;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_next;
  logic [7:0]    r_data;
  logic          r_tx;
  logic          w_tx_next;
  logic          w_baud_end;

  assign w_baud_end = (r_baud == BW'(BAUD_DIV - 1));

  // Next-state logic: every non-IDLE state lasts BAUD_DIV cycles.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_pop        = 1'b0;
    if (r_state != S_IDLE) w_baud_next = w_baud_end ? '0 : r_baud + BW'(1);
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
          w_baud_next  = '0;
          w_bit_next   = '0;
        end
      end
      S_START: if (w_baud_end) w_state_next = S_DATA;
      S_DATA: begin
        if (w_baud_end) begin
          if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (w_baud_end) w_state_next = S_STOP;
`endif
      S_STOP: if (w_baud_end) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Line level for the upcoming state, registered so tx is glitch-free.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_data[w_bit_next];
`ifdef UART_PARITY_EN
      S_PARITY: w_tx_next = ^r_data;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  // TX state register, bit timing, latched byte and line driver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_tx    <= w_tx_next;
      if (w_pop) r_data <= r_fifo[r_rptr];
    end
  end

  assign pins.tx        = r_tx;
  assign pins.led_act   = (r_state != S_IDLE) || (|r_stable);
  assign pins.led_ovf   = r_ovf;
  assign o_dbg_tx_state = r_state;
endmodule

// File: tb/tb_key_matrix_uart.sv
// Bench for key_matrix_uart. A behavioural keyboard (one bit per key) drives
// the rows from the strobed column; the expected byte stream is derived from
// which keys change at a scan boundary, in ascending key order.
module tb_key_matrix_uart;
  localparam int COLS       = 5;
  localparam int ROWS       = 15;
  localparam int SCAN_DIV   = 32;
  localparam int DEBOUNCE   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int BAUD_DIV   = 16;
  localparam int NKEYS      = COLS * ROWS;
  localparam int SCAN_PER   = COLS * SCAN_DIV;
  localparam int RX_TIMEOUT = (DEBOUNCE + 4) * SCAN_PER;
  localparam int QUIET      = (DEBOUNCE + 1) * SCAN_PER;
  localparam logic [COLS-1:0] ALL1 = '1;
  localparam logic [COLS-1:0] COL0 = ~(COLS'(1));
  localparam logic [COLS-1:0] COL1 = ~(COLS'(2));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_matrix_uart_if #(.COLS(COLS), .ROWS(ROWS)) kb ();
  logic [2:0] dbg_state;

  key_matrix_uart #(
    .COLS(COLS), .ROWS(ROWS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
    .FIFO_DEPTH(FIFO_DEPTH), .BAUD_DIV(BAUD_DIV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pins(kb),
    .o_dbg_tx_state(dbg_state)
  );

  // ---------------- keyboard model ----------------
  logic [NKEYS-1:0] pressed = '0;
  logic [ROWS-1:0]  w_row_n;

  always_comb begin
    w_row_n = '1;
    for (int c = 0; c < COLS; c++)
      if (kb.col_n[c] == 1'b0)
        for (int r = 0; r < ROWS; r++)
          if (pressed[c*ROWS + r]) w_row_n[r] = 1'b0;
  end
  assign kb.row_n = w_row_n;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic       ovf_exp = 1'b0;
  logic       mon_tx_low = 1'b0;
  logic       mon_act = 1'b0;
  int         n_chk = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic watch();
    if (kb.tx == 1'b0) mon_tx_low = 1'b1;
    if (kb.led_act)    mon_act = 1'b1;
  endtask

  task automatic idle_watch(input int n);
    repeat (n) begin
      @(negedge clk);
      watch();
    end
  endtask

  // Return at the negedge where column 0 has just become strobed.
  task automatic wait_scan_start();
    int t;
    t = 0;
    while (kb.col_n == COL0 && t < 2*SCAN_PER) begin @(negedge clk); watch(); t++; end
    while (kb.col_n != COL0 && t < 4*SCAN_PER) begin @(negedge clk); watch(); t++; end
    if (kb.col_n != COL0) check("scan_start_timeout", kb.col_n, COL0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    pressed = '0;
    exp_q.delete();
    ovf_exp = 1'b0;
    #1;
    check("rst_tx", kb.tx, 1);
    check("rst_col_n", kb.col_n, ALL1);
    check("rst_led_act", kb.led_act, 0);
    check("rst_led_ovf", kb.led_ovf, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // UART receiver: sample each bit at its middle.
  task automatic rx_byte(output logic [7:0] b, output logic p, output logic ok);
    int t;
    ok = 1'b0;
    b  = '0;
    p  = 1'b0;
    t  = 0;
    while (kb.tx !== 1'b0 && t < RX_TIMEOUT) begin @(negedge clk); t++; end
    if (kb.tx !== 1'b0) return;
    repeat (BAUD_DIV/2) @(negedge clk);
    check("start_bit", kb.tx, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (BAUD_DIV) @(negedge clk);
      b[i] = kb.tx;
    end
`ifdef UART_PARITY_EN
    repeat (BAUD_DIV) @(negedge clk);
    p = kb.tx;
`endif
    repeat (BAUD_DIV) @(negedge clk);
    check("stop_bit", kb.tx, 1);
    ok = 1'b1;
  endtask

  // Receive every expected byte, then require a quiet line and settled LEDs.
  task automatic drain();
    logic [7:0] e;
    logic [7:0] b;
    logic       p;
    logic       ok;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      rx_byte(b, p, ok);
      check("rx_arrived", ok, 1);
      if (!ok) begin
        exp_q.delete();
      end else begin
        check("rx_byte", b, e);
`ifdef UART_PARITY_EN
        check("rx_parity", p, ^e);
`endif
      end
    end
    mon_tx_low = 1'b0;
    mon_act    = 1'b0;
    idle_watch(QUIET);
    check("no_extra_byte", mon_tx_low, 0);
    check("led_act", kb.led_act, |pressed);
    check("led_ovf", kb.led_ovf, ovf_exp);
  endtask

  // Flip the given keys at a scan boundary; each flip is one event, key order ascending.
  task automatic run_toggles(input logic [NKEYS-1:0] tog);
    wait_scan_start();
    for (int k = 0; k < NKEYS; k++) begin
      if (tog[k]) begin
        pressed[k] = ~pressed[k];
        exp_q.push_back({~pressed[k], 7'(k)});
      end
    end
    drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [NKEYS-1:0] tog;
    int n;

    do_reset();
    #1 check("col_n_before_first_edge", kb.col_n, ALL1);
    @(negedge clk);
    check("col_n_first_dwell", kb.col_n, COL0);
    n = 0;
    while (kb.col_n == COL0 && n < 4*SCAN_DIV) begin n++; @(negedge clk); end
    check("dwell_len", n, SCAN_DIV);
    check("col_n_second_dwell", kb.col_n, COL1);

    // Bounce shorter than the debounce window: key 33 toggles every scan.
    mon_tx_low = 1'b0;
    mon_act    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_scan_start();
      pressed[33] = (i % 2 == 0);
    end
    idle_watch(QUIET);
    check("bounce_no_byte", mon_tx_low, 0);
    check("bounce_led_act", mon_act, 0);

    // Key 33 make then break: 0x21, 0xA1.
    tog = '0; tog[33] = 1'b1;
    run_toggles(tog);
    run_toggles(tog);

    // Column 1 rows 0 and 7 together: 0x0F then 0x16, and the breaks.
    tog = '0; tog[15] = 1'b1; tog[22] = 1'b1;
    run_toggles(tog);
    run_toggles(tog);

    // Random phases of 1..3 key flips (never enough to fill the FIFO).
    for (int ph = 0; ph < 12; ph++) begin
      tog = '0;
      n = $urandom_range(1, 3);
      while ($countones(tog) < n) tog[$urandom_range(0, NKEYS-1)] = 1'b1;
      run_toggles(tog);
    end

    // Six keys of one column at once overflow a 4-deep FIFO; all still arrive in order.
    do_reset();
    tog = '0;
    for (int k = 0; k < 6; k++) tog[k] = 1'b1;
    ovf_exp = 1'b1;
    run_toggles(tog);
    run_toggles(tog);

    // Reset in the middle of a frame: line idles at once and nothing follows.
    wait_scan_start();
    pressed[33] = 1'b1;
    n = 0;
    while (kb.tx !== 1'b0 && n < RX_TIMEOUT) begin @(negedge clk); n++; end
    check("mid_frame_start_seen", kb.tx, 0);
    repeat (3*BAUD_DIV) @(negedge clk);
    do_reset();
    mon_tx_low = 1'b0;
    idle_watch(2*QUIET);
    check("post_reset_quiet", mon_tx_low, 0);
    check("post_reset_led_act", kb.led_act, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
